// File: rtl/sram_controller_pkg.sv
// Shared definitions for the memory-stage SRAM controller.
// Holds the FSM state encoding and the default byte address mapped to SRAM word 0.
package sram_controller_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLow  = 2'd1,
    StHigh = 2'd2,
    StDone = 2'd3
  } sram_state_e;

  localparam logic [31:0] DefaultBaseAddr = 32'd1024;

endpackage

// File: rtl/sram_controller.sv
// Memory-stage controller: turns single-cycle word loads/stores into two 16-bit
// half-accesses on an asynchronous external SRAM, freezing the pipeline via ready_o.
//
// Ports:
//   clk, rst      clock and asynchronous active-high reset
//   wr_en_i       store request (wins over rd_en_i when both are set)
//   rd_en_i       load request
//   address_i     byte address from the ALU
//   write_data_i  store data
//   read_data_o   last loaded word (to MEM/WB)
//   ready_o       0 freezes every pipeline register and the PC
//   sram_dq_io    SRAM data bus
//   sram_addr_o   SRAM half-word address
//   sram_we_n_o   SRAM write enable, active low
//   sram_oe_n_o   SRAM output enable, active low
module sram_controller
  import sram_controller_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR     = DefaultBaseAddr,
  parameter int unsigned ACCESS_CYCLES = 2,
  parameter int unsigned SRAM_AW       = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en_i,
  input  logic               rd_en_i,
  input  logic [31:0]        address_i,
  input  logic [31:0]        write_data_i,
  output logic [31:0]        read_data_o,
  output logic               ready_o,
  inout  wire  [15:0]        sram_dq_io,
  output logic [SRAM_AW-1:0] sram_addr_o,
  output logic               sram_we_n_o,
  output logic               sram_oe_n_o
);

  localparam int unsigned CntW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(ACCESS_CYCLES - 1);

  sram_state_e        state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [SRAM_AW-2:0] word_q, word_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               is_wr_q, is_wr_d;
  logic [31:0]        rdata_q, rdata_d;

  logic [31:0] off;
  logic        half_last;
  logic        active;
  logic        drive;
  logic        unused_off;

  // Offset wraps modulo 2^32; only the word-index bits reach the SRAM.
  assign off        = address_i - BASE_ADDR;
  assign unused_off = ^{off[31:SRAM_AW+1], off[1:0]};
  assign half_last  = (cnt_q == CntLast);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    wdata_d = wdata_q;
    is_wr_d = is_wr_q;
    rdata_d = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (wr_en_i || rd_en_i) begin
          word_d  = off[SRAM_AW:2];
          wdata_d = write_data_i;
          is_wr_d = wr_en_i;
          cnt_d   = '0;
          state_d = StLow;
        end
      end
      StLow: begin
        if (half_last) begin
          cnt_d   = '0;
          state_d = StHigh;
          if (!is_wr_q) rdata_d[15:0] = sram_dq_io;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StHigh: begin
        if (half_last) begin
          cnt_d   = '0;
          state_d = StDone;
          if (!is_wr_q) rdata_d[31:16] = sram_dq_io;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      word_q  <= '0;
      wdata_q <= '0;
      is_wr_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      wdata_q <= wdata_d;
      is_wr_q <= is_wr_d;
      rdata_q <= rdata_d;
    end
  end

  assign active = (state_q == StLow) || (state_q == StHigh);
  assign drive  = active && is_wr_q;

  always_comb begin
    sram_addr_o = '0;
    if (active) sram_addr_o = {word_q, state_q == StHigh};
  end

  // WE rises on the last cycle of a half so data is still valid at the rising edge;
  // a single-cycle half has no room for that and keeps WE low throughout.
  assign sram_we_n_o = ~(drive && (!half_last || (ACCESS_CYCLES == 1)));
  assign sram_oe_n_o = ~(active && !is_wr_q);
  assign sram_dq_io  = drive ? ((state_q == StHigh) ? wdata_q[31:16] : wdata_q[15:0])
                             : 16'hzzzz;

  assign read_data_o = rdata_q;
  assign ready_o     = ~(rd_en_i | wr_en_i) | (state_q == StDone);

endmodule
